// File: rtl/viterbi_acs_k3_if.sv
// Symbol-in / decision-out handshake bundle for the K=3 add-compare-select stage.
interface viterbi_acs_k3_if #(
  parameter int PM_W = 8
) ();
  logic            rx_sym_valid;
  logic            rx_sym_ready;
  logic [1:0]      rx_sym;
  logic            dec_valid;
  logic            dec_ready;
  logic [3:0]      dec_bits;
  logic [1:0]      dec_best;
  logic [PM_W-1:0] dec_pm_min;

  modport master (
    output rx_sym_valid, rx_sym, dec_ready,
    input  rx_sym_ready, dec_valid, dec_bits, dec_best, dec_pm_min
  );

  modport slave (
    input  rx_sym_valid, rx_sym, dec_ready,
    output rx_sym_ready, dec_valid, dec_bits, dec_best, dec_pm_min
  );
endinterface

// File: rtl/viterbi_acs_k3.sv
// Four-state (K=3, g0=7, g1=5) hard-decision ACS: one trellis step per accepted
// symbol, survivor bits and normalized path metrics handed to traceback.
module viterbi_acs_k3 #(
  parameter int PM_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sync_clr,
  viterbi_acs_k3_if.slave       bus,
  output logic [15:0]           step_cnt
);
  localparam int NUM_ST = 4;
  localparam logic [PM_W:0]   HALF    = (PM_W+1)'(2**(PM_W-1));
  localparam logic [PM_W-1:0] PM_INIT = PM_W'(2**(PM_W-2));
  localparam logic [NUM_ST-1:0][PM_W-1:0] PM_RST =
    {PM_INIT, PM_INIT, PM_INIT, {PM_W{1'b0}}};

  logic [NUM_ST-1:0][PM_W-1:0] r_pm;
  logic [3:0]                  r_bits;
  logic [1:0]                  r_best;
  logic [PM_W-1:0]             r_pm_min;
  logic                        r_dec_valid;
  logic [15:0]                 r_step;

  logic [NUM_ST-1:0][PM_W:0]   w_raw;
  logic [NUM_ST-1:0][PM_W-1:0] w_pm_next;
  logic [NUM_ST-1:0]           w_sel;
  logic [PM_W:0]               w_min;
  logic [PM_W:0]               w_sub;
  logic [1:0]                  w_best;
  logic                        w_ready;
  logic                        w_acc;

  // Hamming distance between the received pair and the branch label of p --u-->
  function automatic logic [1:0] f_bm(input logic [1:0] p, input logic u,
                                      input logic [1:0] sym);
    logic c0, c1;
    c0 = u ^ p[1] ^ p[0];
    c1 = u ^ p[0];
    return {1'b0, sym[0] ^ c0} + {1'b0, sym[1] ^ c1};
  endfunction

  genvar n;
  generate
    for (n = 0; n < NUM_ST; n++) begin : g_acs
      localparam logic [1:0] P0 = 2'((n % 2) * 2);
      localparam logic [1:0] P1 = 2'((n % 2) * 2 + 1);
      localparam logic       U  = 1'(n / 2);
      logic [PM_W:0] w_c0, w_c1;
      assign w_c0     = {1'b0, r_pm[P0]} + (PM_W+1)'(f_bm(P0, U, bus.rx_sym));
      assign w_c1     = {1'b0, r_pm[P1]} + (PM_W+1)'(f_bm(P1, U, bus.rx_sym));
      assign w_sel[n] = (w_c1 < w_c0);
      assign w_raw[n] = w_sel[n] ? w_c1 : w_c0;
      assign w_pm_next[n] = PM_W'(w_raw[n] - w_sub);
    end
  endgenerate

  // Strict compare keeps the lowest index on ties.
  always_comb begin
    w_best = '0;
    w_min  = w_raw[0];
    for (int i = 1; i < NUM_ST; i++) begin
      if (w_raw[i] < w_min) begin
        w_min  = w_raw[i];
        w_best = 2'(i);
      end
    end
  end

  assign w_sub   = (w_min >= HALF) ? HALF : '0;
  assign w_ready = (!r_dec_valid || bus.dec_ready) && !sync_clr;
  assign w_acc   = bus.rx_sym_valid && w_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pm        <= PM_RST;
      r_bits      <= '0;
      r_best      <= '0;
      r_pm_min    <= '0;
      r_dec_valid <= 1'b0;
      r_step      <= '0;
    end else if (sync_clr) begin
      r_pm        <= PM_RST;
      r_step      <= '0;
      r_dec_valid <= 1'b0;
    end else if (w_acc) begin
      r_pm        <= w_pm_next;
      r_bits      <= w_sel;
      r_best      <= w_best;
      r_pm_min    <= PM_W'(w_min - w_sub);
      r_dec_valid <= 1'b1;
      r_step      <= r_step + 16'd1;
    end else if (bus.dec_ready) begin
      r_dec_valid <= 1'b0;
    end
  end

  assign bus.rx_sym_ready = w_ready;
  assign bus.dec_valid    = r_dec_valid;
  assign bus.dec_bits     = r_bits;
  assign bus.dec_best     = r_best;
  assign bus.dec_pm_min   = r_pm_min;
  assign step_cnt         = r_step;
endmodule
